// File: rtl/simd_acc_pkg.sv
// rtl/simd_acc_pkg.sv - shared mode encoding, lane counts, FSM states and HALF decode
package simd_acc_pkg;

  localparam logic [1:0] MODE_32 = 2'd0;
  localparam logic [1:0] MODE_16 = 2'd1;
  localparam logic [1:0] MODE_8  = 2'd2;

  localparam int LANES_32 = 1;
  localparam int LANES_16 = 2;
  localparam int LANES_8  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic       legal;
    logic [1:0] mode;
  } half_dec_t;

  // half = {HALF_2, HALF_1, HALF_0}; anything not exactly one-hot is illegal
  function automatic half_dec_t half_decode(input logic [2:0] half);
    half_dec_t d;
    d.legal = 1'b1;
    d.mode  = MODE_32;
    case (half)
      3'b001:  d.mode = MODE_32;
      3'b010:  d.mode = MODE_16;
      3'b100:  d.mode = MODE_8;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] last_lane(input logic [1:0] mode);
    case (mode)
      MODE_16: return 2'(LANES_16 - 1);
      MODE_8:  return 2'(LANES_8 - 1);
      default: return 2'(LANES_32 - 1);
    endcase
  endfunction

endpackage

// File: rtl/simd_lane_extract.sv
// rtl/simd_lane_extract.sv - slices a packed product beat into 4 extended lanes
module simd_lane_extract
  import simd_acc_pkg::*;
#(
  parameter int C_WIDTH   = 32,
  parameter int ACC_WIDTH = 40
) (
  input  logic [C_WIDTH-1:0]            c_i,
  input  logic [1:0]                    mode_i,
  input  logic                          sign_i,
  output logic [3:0][ACC_WIDTH-1:0]     lane_o
);

  always_comb begin
    lane_o = '0;
    case (mode_i)
      MODE_32: begin
        lane_o[0] = sign_i ? ACC_WIDTH'($signed(c_i[31:0])) : ACC_WIDTH'(c_i[31:0]);
      end
      MODE_16: begin
        for (int i = 0; i < LANES_16; i++) begin
          lane_o[i] = sign_i ? ACC_WIDTH'($signed(c_i[16*i +: 16])) : ACC_WIDTH'(c_i[16*i +: 16]);
        end
      end
      MODE_8: begin
        for (int i = 0; i < LANES_8; i++) begin
          lane_o[i] = sign_i ? ACC_WIDTH'($signed(c_i[8*i +: 8])) : ACC_WIDTH'(c_i[8*i +: 8]);
        end
      end
      default: lane_o = '0;
    endcase
  end

endmodule

// File: rtl/simd_product_accumulator.sv
// rtl/simd_product_accumulator.sv - per-lane batch accumulator with lane-serial drain
module simd_product_accumulator
  import simd_acc_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int ACC_WIDTH   = 40,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [C_WIDTH-1:0]     in_C,
  input  logic                   in_sign,
  input  logic                   in_HALF_0,
  input  logic                   in_HALF_1,
  input  logic                   in_HALF_2,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_lane,
  output logic [ACC_WIDTH-1:0]   out_acc,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   err_mode
);

  state_e                        state_q, state_d;
  logic [1:0]                    mode_q, mode_d;
  logic                          sign_q, sign_d;
  logic [3:0][ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [COUNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [1:0]                    lane_q, lane_d;
  logic                          err_q, err_d;

  logic [3:0][ACC_WIDTH-1:0]     ext_lanes;
  half_dec_t                     dec;
  logic                          beat_fire;

  assign dec       = half_decode({in_HALF_2, in_HALF_1, in_HALF_0});
  assign in_ready  = (state_q != ST_DRAIN);
  assign out_valid = (state_q == ST_DRAIN);
  assign beat_fire = in_valid & in_ready;

  assign out_lane  = lane_q;
  assign out_acc   = out_valid ? acc_q[lane_q] : '0;
  assign out_count = cnt_q;
  assign err_mode  = err_q;

  // Extraction follows the incoming beat's mode; a legal ACCUM beat matches the latched mode anyway
  simd_lane_extract #(
    .C_WIDTH  (C_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_extract (
    .c_i   (in_C),
    .mode_i(dec.mode),
    .sign_i(in_sign),
    .lane_o(ext_lanes)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat_fire) begin
          if (!dec.legal) begin
            err_d = 1'b1;
          end else begin
            mode_d  = dec.mode;
            sign_d  = in_sign;
            acc_d   = ext_lanes;
            cnt_d   = COUNT_WIDTH'(1);
            state_d = in_last ? ST_DRAIN : ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (beat_fire) begin
          // Illegal beats are still consumed and counted, only their data is dropped
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          if (!dec.legal || dec.mode != mode_q || in_sign != sign_q) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < 4; i++) acc_d[i] = acc_q[i] + ext_lanes[i];
          end
          if (in_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (lane_q == last_lane(mode_q)) begin
            acc_d   = '0;
            cnt_d   = '0;
            lane_d  = 2'd0;
            state_d = ST_IDLE;
          end else begin
            lane_d = lane_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_32;
      sign_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      lane_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_simd_product_accumulator.sv
// tb/tb_simd_product_accumulator.sv - directed vector bench for simd_product_accumulator
module tb_simd_product_accumulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_C;
  logic        in_sign;
  logic        in_HALF_0, in_HALF_1, in_HALF_2;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_lane;
  logic [39:0] out_acc;
  logic [7:0]  out_count;
  logic        err_mode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  simd_product_accumulator #(
    .C_WIDTH    (32),
    .ACC_WIDTH  (40),
    .COUNT_WIDTH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_C     (in_C),
    .in_sign  (in_sign),
    .in_HALF_0(in_HALF_0),
    .in_HALF_1(in_HALF_1),
    .in_HALF_2(in_HALF_2),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_lane (out_lane),
    .out_acc  (out_acc),
    .out_count(out_count),
    .err_mode (err_mode)
  );

  typedef struct {
    logic [2:0]       half;
    logic             sign;
    logic [31:0]      data;
    int               beats;
    int               nl;
    logic [3:0][39:0] exp;
    logic [7:0]       cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Inputs change on the negedge, the DUT captures on the following posedge
  task automatic send_beat(input logic [2:0] half, input logic sign, input logic [31:0] data,
                           input logic last);
    in_valid = 1'b1;
    {in_HALF_2, in_HALF_1, in_HALF_0} = half;
    in_sign  = sign;
    in_C     = data;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string tag, input int nl, input logic [3:0][39:0] exp,
                       input logic [7:0] cnt);
    for (int i = 0; i < nl; i++) begin
      chk($sformatf("%s valid%0d", tag, i), out_valid, 1);
      chk($sformatf("%s lane%0d", tag, i), out_lane, i);
      chk($sformatf("%s acc%0d", tag, i), out_acc, exp[i]);
      chk($sformatf("%s count%0d", tag, i), out_count, cnt);
      chk($sformatf("%s in_ready%0d", tag, i), in_ready, 0);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk($sformatf("%s idle valid", tag), out_valid, 0);
    chk($sformatf("%s idle in_ready", tag), in_ready, 1);
    chk($sformatf("%s idle count", tag), out_count, 0);
  endtask

  initial begin
    vecs[0] = '{3'b001, 1'b0, 32'h0000_0010, 3, 1,
                {40'h0, 40'h0, 40'h0, 40'h30}, 8'd3};
    vecs[1] = '{3'b001, 1'b1, 32'hFFFE_0001, 1, 1,
                {40'h0, 40'h0, 40'h0, 40'hFF_FFFE_0001}, 8'd1};
    vecs[2] = '{3'b100, 1'b1, 32'hF87F_01FF, 1, 4,
                {40'hFF_FFFF_FFF8, 40'h7F, 40'h1, 40'hFF_FFFF_FFFF}, 8'd1};
    vecs[3] = '{3'b100, 1'b0, 32'hF87F_01FF, 1, 4,
                {40'hF8, 40'h7F, 40'h1, 40'hFF}, 8'd1};
    vecs[4] = '{3'b010, 1'b0, 32'h0001_FFFF, 2, 2,
                {40'h0, 40'h0, 40'h2, 40'h1_FFFE}, 8'd2};

    reset = 1'b1; in_valid = 1'b0; in_C = '0; in_sign = 1'b0;
    in_HALF_0 = 1'b0; in_HALF_1 = 1'b0; in_HALF_2 = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready", in_ready, 1);
    chk("reset err_mode", err_mode, 0);
    chk("reset out_acc", out_acc, 0);
    chk("reset out_lane", out_lane, 0);
    chk("reset out_count", out_count, 0);

    // Table: back-to-back batches, drain starts the cycle after the last beat
    for (int v = 0; v < 5; v++) begin
      for (int b = 0; b < vecs[v].beats; b++)
        send_beat(vecs[v].half, vecs[v].sign, vecs[v].data, b == vecs[v].beats - 1);
      drain($sformatf("vec%0d", v), vecs[v].nl, vecs[v].exp, vecs[v].cnt);
    end

    // 2x16 signed with a three-cycle downstream stall
    send_beat(3'b010, 1'b1, 32'hFFF0_0005, 1'b0);
    send_beat(3'b010, 1'b1, 32'hFFF0_0005, 1'b1);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("stall%0d valid", s), out_valid, 1);
      chk($sformatf("stall%0d lane", s), out_lane, 0);
      chk($sformatf("stall%0d acc", s), out_acc, 40'hA);
      chk($sformatf("stall%0d count", s), out_count, 2);
      @(negedge clk);
    end
    drain("stall", 2, {40'h0, 40'h0, 40'hFF_FFFF_FFE0, 40'hA}, 8'd2);

    // Mode change mid-batch: beat consumed and counted, data dropped
    send_beat(3'b001, 1'b0, 32'h1, 1'b0);
    chk("modechg err beat1", err_mode, 0);
    send_beat(3'b010, 1'b0, 32'h0001_0001, 1'b0);
    chk("modechg err beat2", err_mode, 1);
    send_beat(3'b001, 1'b0, 32'h2, 1'b1);
    chk("modechg err beat3", err_mode, 0);
    drain("modechg", 1, {40'h0, 40'h0, 40'h0, 40'h3}, 8'd3);

    // Non-one-hot HALF in IDLE carries no batch even with last
    send_beat(3'b011, 1'b0, 32'h7, 1'b1);
    chk("idle illegal err", err_mode, 1);
    chk("idle illegal valid", out_valid, 0);
    chk("idle illegal in_ready", in_ready, 1);
    @(negedge clk);
    chk("idle illegal err clear", err_mode, 0);
    chk("idle illegal still idle", out_valid, 0);

    // Counter saturates at 255 while accumulators keep summing
    for (int b = 0; b < 300; b++)
      send_beat(3'b100, 1'b0, 32'h0101_0101, b == 299);
    drain("sat", 4, {40'h12C, 40'h12C, 40'h12C, 40'h12C}, 8'hFF);

    // Reset mid-drain discards the remaining lanes
    send_beat(3'b100, 1'b1, 32'hF87F_01FF, 1'b1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    chk("middrain lane", out_lane, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("middrain reset valid", out_valid, 0);
    chk("middrain reset acc", out_acc, 0);
    chk("middrain reset count", out_count, 0);
    chk("middrain reset in_ready", in_ready, 1);
    send_beat(3'b001, 1'b0, 32'h5, 1'b1);
    drain("postreset", 1, {40'h0, 40'h0, 40'h0, 40'h5}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
